// File: rtl/wb_trap_commit_if.sv
// rtl/wb_trap_commit_if.sv - WB-side CSR/exception fields, decode CSR read port and redirect/flush outputs
interface wb_trap_commit_if;
  logic        WBvalid;
  logic        WBstall;
  logic [63:0] WBnpc;
  logic        except_wb_except;
  logic [63:0] except_wb_epc;
  logic [63:0] except_wb_ecause;
  logic [63:0] except_wb_etval;
  logic [11:0] csr_addr_WB;
  logic [63:0] csr_val_WB;
  logic        csr_we_WB;
  logic [1:0]  csr_ret_WB;
  logic        mtip;
  logic [11:0] csr_raddr;
  logic [63:0] csr_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        flush_out;
  logic        trap_active;

  modport master (
    output WBvalid, WBstall, WBnpc, except_wb_except, except_wb_epc, except_wb_ecause,
           except_wb_etval, csr_addr_WB, csr_val_WB, csr_we_WB, csr_ret_WB, mtip, csr_raddr,
    input  csr_rdata, redirect_valid, redirect_pc, flush_out, trap_active
  );

  modport slave (
    input  WBvalid, WBstall, WBnpc, except_wb_except, except_wb_epc, except_wb_ecause,
           except_wb_etval, csr_addr_WB, csr_val_WB, csr_we_WB, csr_ret_WB, mtip, csr_raddr,
    output csr_rdata, redirect_valid, redirect_pc, flush_out, trap_active
  );
endinterface

// File: rtl/wb_trap_commit.sv
// rtl/wb_trap_commit.sv - machine-mode trap CSRs, trap/mret commit, PC redirect and pipeline flush
module wb_trap_commit #(
  parameter logic [63:0] RESET_MTVEC  = 64'h0,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input logic           clk,
  input logic           rst,
  wb_trap_commit_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PEND  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  localparam logic [63:0] IRQ_CAUSE  = 64'h8000_0000_0000_0007;
  localparam logic [3:0]  FLUSH_LOAD = 4'(FLUSH_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ev_ret_q, ev_ret_d;
  logic [63:0] tgt_q, tgt_d;
  logic [63:0] nepc_q, nepc_d;
  logic [63:0] ncause_q, ncause_d;
  logic [63:0] ntval_q, ntval_d;
  logic        st_mie_q, st_mie_d;
  logic        st_mpie_q, st_mpie_d;
  logic        mtie_q, mtie_d;
  logic [63:0] mtvec_q, mtvec_d;
  logic [63:0] mscratch_q, mscratch_d;
  logic [63:0] mepc_q, mepc_d;
  logic [63:0] mcause_q, mcause_d;
  logic [63:0] mtval_q, mtval_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [63:0] redirect_pc_q, redirect_pc_d;

  logic        sample;
  logic        irq_take;
  logic [63:0] mtvec_base;
  logic [63:0] mstatus_val;

  assign sample      = (state_q == S_IDLE) && bus.WBvalid && !bus.WBstall;
  assign irq_take    = st_mie_q && mtie_q && bus.mtip && !bus.csr_we_WB && (bus.csr_ret_WB != 2'b11);
  assign mtvec_base  = mtvec_q & ~64'h3;
  assign mstatus_val = {51'd0, 2'b11, 3'd0, st_mpie_q, 3'd0, st_mie_q, 3'd0};

  // The event is latched at the sampling edge; CSR side effects and the redirect land one edge later.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    ev_ret_d         = ev_ret_q;
    tgt_d            = tgt_q;
    nepc_d           = nepc_q;
    ncause_d         = ncause_q;
    ntval_d          = ntval_q;
    st_mie_d         = st_mie_q;
    st_mpie_d        = st_mpie_q;
    mtie_d           = mtie_q;
    mtvec_d          = mtvec_q;
    mscratch_d       = mscratch_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    mtval_d          = mtval_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;

    case (state_q)
      S_IDLE: begin
        if (sample) begin
          if (bus.except_wb_except) begin
            state_d  = S_PEND;
            ev_ret_d = 1'b0;
            nepc_d   = bus.except_wb_epc & ~64'h3;
            ncause_d = bus.except_wb_ecause;
            ntval_d  = bus.except_wb_etval;
            tgt_d    = mtvec_base;
          end else begin
            if (bus.csr_we_WB) begin
              case (bus.csr_addr_WB)
                CSR_MSTATUS: begin
                  st_mie_d  = bus.csr_val_WB[3];
                  st_mpie_d = bus.csr_val_WB[7];
                end
                CSR_MIE:      mtie_d     = bus.csr_val_WB[7];
                CSR_MTVEC:    mtvec_d    = {bus.csr_val_WB[63:2],
                                            bus.csr_val_WB[1] ? 2'b00 : bus.csr_val_WB[1:0]};
                CSR_MSCRATCH: mscratch_d = bus.csr_val_WB;
                CSR_MEPC:     mepc_d     = bus.csr_val_WB & ~64'h3;
                CSR_MCAUSE:   mcause_d   = bus.csr_val_WB;
                CSR_MTVAL:    mtval_d    = bus.csr_val_WB;
                default: ;
              endcase
            end
            if (irq_take) begin
              state_d  = S_PEND;
              ev_ret_d = 1'b0;
              nepc_d   = bus.WBnpc & ~64'h3;
              ncause_d = IRQ_CAUSE;
              ntval_d  = 64'd0;
              tgt_d    = (mtvec_q[1:0] == 2'b01) ? mtvec_base + 64'd28 : mtvec_base;
            end else if (bus.csr_ret_WB == 2'b11) begin
              state_d  = S_PEND;
              ev_ret_d = 1'b1;
              tgt_d    = mepc_q;
            end
          end
        end
      end
      S_PEND: begin
        if (ev_ret_q) begin
          st_mie_d  = st_mpie_q;
          st_mpie_d = 1'b1;
        end else begin
          mepc_d    = nepc_q;
          mcause_d  = ncause_q;
          mtval_d   = ntval_q;
          st_mpie_d = st_mie_q;
          st_mie_d  = 1'b0;
        end
        redirect_valid_d = 1'b1;
        redirect_pc_d    = tgt_q;
        state_d          = S_FLUSH;
        cnt_d            = FLUSH_LOAD;
      end
      S_FLUSH: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      cnt_q            <= 4'd0;
      ev_ret_q         <= 1'b0;
      tgt_q            <= 64'd0;
      nepc_q           <= 64'd0;
      ncause_q         <= 64'd0;
      ntval_q          <= 64'd0;
      st_mie_q         <= 1'b0;
      st_mpie_q        <= 1'b0;
      mtie_q           <= 1'b0;
      mtvec_q          <= RESET_MTVEC;
      mscratch_q       <= 64'd0;
      mepc_q           <= 64'd0;
      mcause_q         <= 64'd0;
      mtval_q          <= 64'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 64'd0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      ev_ret_q         <= ev_ret_d;
      tgt_q            <= tgt_d;
      nepc_q           <= nepc_d;
      ncause_q         <= ncause_d;
      ntval_q          <= ntval_d;
      st_mie_q         <= st_mie_d;
      st_mpie_q        <= st_mpie_d;
      mtie_q           <= mtie_d;
      mtvec_q          <= mtvec_d;
      mscratch_q       <= mscratch_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      mtval_q          <= mtval_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  always_comb begin
    bus.csr_rdata = 64'd0;
    case (bus.csr_raddr)
      CSR_MSTATUS:  bus.csr_rdata = mstatus_val;
      CSR_MIE:      bus.csr_rdata = {56'd0, mtie_q, 7'd0};
      CSR_MTVEC:    bus.csr_rdata = mtvec_q;
      CSR_MSCRATCH: bus.csr_rdata = mscratch_q;
      CSR_MEPC:     bus.csr_rdata = mepc_q;
      CSR_MCAUSE:   bus.csr_rdata = mcause_q;
      CSR_MTVAL:    bus.csr_rdata = mtval_q;
      CSR_MIP:      bus.csr_rdata = {56'd0, bus.mtip, 7'd0};
      default:      bus.csr_rdata = 64'd0;
    endcase
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush_out      = (state_q == S_FLUSH);
  assign bus.trap_active    = (state_q == S_FLUSH);

endmodule

// File: tb/tb_wb_trap_commit.sv
// tb/tb_wb_trap_commit.sv - directed bench for wb_trap_commit with a cycle-level reference model
module tb_wb_trap_commit;
  localparam logic [63:0] RMTVEC = 64'h400;
  localparam int          FC     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_trap_commit_if bus ();

  wb_trap_commit #(.RESET_MTVEC(RMTVEC), .FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int rv_cnt  = 0;
  logic chk_en = 1'b0;

  logic [63:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_rpc;
  logic        m_mie, m_mpie, m_mtie, m_rv;
  logic        m_pend, p_ret, irq;
  logic [63:0] p_tgt, p_epc, p_cause, p_tval, base, old_mepc;
  int          m_flush;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return 64'h1800 | (64'(m_mpie) << 7) | (64'(m_mie) << 3);
      12'h304: return 64'(m_mtie) << 7;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return 64'(bus.mtip) << 7;
      default: return 64'd0;
    endcase
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [63:0] v);
    case (a)
      12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
      12'h304: m_mtie = v[7];
      12'h305: m_mtvec = v[1] ? (v & ~64'h3) : v;
      12'h340: m_mscratch = v;
      12'h341: m_mepc = v & ~64'h3;
      12'h342: m_mcause = v;
      12'h343: m_mtval = v;
      default: ;
    endcase
  endtask

  // Reference model: one sampled event commits on the following edge, then FC flush cycles.
  initial begin : model
    forever begin
      @(posedge clk);
      if (rst) begin
        m_mtvec = RMTVEC; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_mie = 0; m_mpie = 0; m_mtie = 0; m_rv = 0; m_rpc = 0; m_pend = 0; m_flush = 0;
      end else begin
        m_rv = 1'b0;
        if (m_pend) begin
          if (p_ret) begin
            m_mie = m_mpie; m_mpie = 1'b1;
          end else begin
            m_mepc = p_epc; m_mcause = p_cause; m_mtval = p_tval; m_mpie = m_mie; m_mie = 1'b0;
          end
          m_rv = 1'b1; m_rpc = p_tgt; m_flush = FC; m_pend = 1'b0;
        end else if (m_flush > 0) begin
          m_flush--;
        end else if (bus.WBvalid && !bus.WBstall) begin
          base = m_mtvec & ~64'h3;
          if (bus.except_wb_except) begin
            m_pend = 1; p_ret = 0; p_tgt = base;
            p_epc = bus.except_wb_epc & ~64'h3; p_cause = bus.except_wb_ecause; p_tval = bus.except_wb_etval;
          end else begin
            irq = m_mie && m_mtie && bus.mtip && !bus.csr_we_WB && bus.csr_ret_WB != 2'b11;
            old_mepc = m_mepc;
            if (bus.csr_we_WB) model_write(bus.csr_addr_WB, bus.csr_val_WB);
            if (irq) begin
              m_pend = 1; p_ret = 0; p_epc = bus.WBnpc & ~64'h3;
              p_cause = 64'h8000_0000_0000_0007; p_tval = 0;
              p_tgt = (m_mtvec[1:0] == 2'b01) ? base + 64'd28 : base;
            end else if (bus.csr_ret_WB == 2'b11) begin
              m_pend = 1; p_ret = 1; p_tgt = old_mepc;
            end
          end
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("redirect_valid", 64'(bus.redirect_valid), 64'(m_rv));
        chk("redirect_pc", bus.redirect_pc, m_rpc);
        chk("flush_out", 64'(bus.flush_out), 64'(m_flush > 0));
        chk("trap_active", 64'(bus.trap_active), 64'(m_flush > 0));
        chk("csr_rdata", bus.csr_rdata, model_read(bus.csr_raddr));
        if (bus.redirect_valid) rv_cnt++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_clear();
    bus.WBvalid = 0; bus.WBstall = 0; bus.WBnpc = 0;
    bus.except_wb_except = 0; bus.except_wb_epc = 0; bus.except_wb_ecause = 0; bus.except_wb_etval = 0;
    bus.csr_addr_WB = 0; bus.csr_val_WB = 0; bus.csr_we_WB = 0; bus.csr_ret_WB = 0;
  endtask

  task automatic wb_write(input logic [11:0] a, input logic [63:0] v);
    bus.WBvalid = 1; bus.csr_we_WB = 1; bus.csr_addr_WB = a; bus.csr_val_WB = v;
    cyc(1);
    wb_clear();
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [63:0] exp);
    bus.csr_raddr = a;
    @(negedge clk);
    chk(name, bus.csr_rdata, exp);
    @(posedge clk); #1;
  endtask

  task automatic exc(input logic [63:0] epc, input logic [63:0] cause, input logic [63:0] tval);
    bus.WBvalid = 1; bus.except_wb_except = 1;
    bus.except_wb_epc = epc; bus.except_wb_ecause = cause; bus.except_wb_etval = tval;
  endtask

  initial begin
    wb_clear();
    bus.mtip = 0; bus.csr_raddr = 0;
    rst = 1;
    cyc(2);
    rst = 0;
    chk_en = 1;

    rd("rst_mstatus", 12'h300, 64'h1800);
    rd("rst_mtvec", 12'h305, RMTVEC);
    rd("rst_mie", 12'h304, 0);
    rd("rst_mscratch", 12'h340, 0);
    rd("rst_mepc", 12'h341, 0);
    rd("rst_mcause", 12'h342, 0);
    rd("rst_mtval", 12'h343, 0);
    rd("rst_mip", 12'h344, 0);
    rd("unmapped", 12'h7C0, 0);

    wb_write(12'h305, 64'h8000_0101);
    rd("mtvec_vec", 12'h305, 64'h8000_0101);
    exc(64'h1002, 64'd2, 64'hDEAD);
    cyc(1); wb_clear(); cyc(1);
    @(negedge clk);
    chk("exc_rv", 64'(bus.redirect_valid), 1);
    chk("exc_pc", bus.redirect_pc, 64'h8000_0100);
    chk("exc_flush1", 64'(bus.flush_out), 1);
    @(negedge clk); chk("exc_flush2", 64'(bus.flush_out), 1);
    @(negedge clk); chk("exc_flush_end", 64'(bus.flush_out), 0);
    @(posedge clk); #1;
    rd("exc_mepc", 12'h341, 64'h1000);
    rd("exc_mcause", 12'h342, 64'd2);
    rd("exc_mtval", 12'h343, 64'hDEAD);
    rd("exc_mstatus", 12'h300, 64'h1800);

    wb_write(12'h300, 64'h8);
    wb_write(12'h304, 64'h80);
    wb_write(12'h305, 64'h101);
    bus.mtip = 1;
    rd("mip", 12'h344, 64'h80);
    bus.WBvalid = 1; bus.WBnpc = 64'h2004;
    cyc(1); wb_clear(); cyc(1);
    @(negedge clk); chk("irq_pc", bus.redirect_pc, 64'h11C);
    @(posedge clk); #1; cyc(2);
    rd("irq_mcause", 12'h342, 64'h8000_0000_0000_0007);
    rd("irq_mepc", 12'h341, 64'h2004);
    rd("irq_mstatus", 12'h300, 64'h1880);

    bus.WBvalid = 1; bus.csr_ret_WB = 2'b11;
    cyc(1); wb_clear(); bus.mtip = 0; cyc(1);
    @(negedge clk); chk("mret_pc", bus.redirect_pc, 64'h2004);
    @(posedge clk); #1; cyc(2);
    rd("mret_mstatus", 12'h300, 64'h1888);

    rv_cnt = 0;
    exc(64'h3000, 64'd5, 64'd0);
    bus.csr_we_WB = 1; bus.csr_addr_WB = 12'h340; bus.csr_val_WB = 64'h55;
    cyc(1);
    bus.except_wb_epc = 64'h4000; bus.csr_val_WB = 64'h77;
    cyc(1 + FC);
    wb_clear();
    wb_write(12'h340, 64'h99);
    cyc(2);
    chk("flush_ignore_rv_cnt", 64'(rv_cnt), 1);
    rd("first_idle_mscratch", 12'h340, 64'h99);
    rd("exc_mepc2", 12'h341, 64'h3000);
    rd("exc_mcause2", 12'h342, 64'd5);

    rv_cnt = 0;
    exc(64'h5000, 64'd7, 64'd0);
    bus.WBstall = 1;
    cyc(3);
    bus.WBstall = 0;
    cyc(1); wb_clear(); cyc(4);
    chk("stall_rv_cnt", 64'(rv_cnt), 1);

    exc(64'h6000, 64'd1, 64'd0);
    cyc(1); wb_clear(); cyc(1);
    bus.csr_raddr = 12'h300;
    rst = 1;
    cyc(1);
    @(negedge clk);
    chk("rst_flush", 64'(bus.flush_out), 0);
    chk("rst_mstatus2", bus.csr_rdata, 64'h1800);
    @(posedge clk); #1;
    rst = 0;

    wb_write(12'h305, 64'hFFFF_FFFF_FFFF_FFF3);
    rd("mtvec_mode1x", 12'h305, 64'hFFFF_FFFF_FFFF_FFF0);
    wb_write(12'h305, 64'hFFFF_FFFF_FFFF_FFF1);
    wb_write(12'h341, 64'h1237);
    rd("mepc_align", 12'h341, 64'h1234);
    wb_write(12'h300, 64'h8);
    wb_write(12'h304, 64'h80);
    bus.mtip = 1;
    bus.WBvalid = 1; bus.WBnpc = 64'h6000;
    cyc(1); wb_clear(); bus.mtip = 0; cyc(1);
    @(negedge clk); chk("irq_wrap_pc", bus.redirect_pc, 64'hC);
    @(posedge clk); #1; cyc(3);
    wb_write(12'h7C0, 64'h5);
    rd("unmapped_wr", 12'h7C0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
